// File: rtl/ktc32_ctrl_if.sv
// ktc32_ctrl_if: memory request/acknowledge bus between the ktc32 control FSM
// (master) and the memory system (slave).
interface ktc32_ctrl_if;
    logic mem_req;  // access request, held until mem_ack is sampled high
    logic mem_we;   // store qualifier, meaningful only while mem_req is high
    logic mem_ack;  // memory completes the current access this cycle

    modport master (output mem_req, output mem_we, input mem_ack);
    modport slave  (input mem_req, input mem_we, output mem_ack);
endinterface

// File: rtl/ktc32_ctrl.sv
// ktc32_ctrl: multicycle main control FSM of the ktc32 core.
// Drives every datapath select/enable from the registered instruction, owns the
// memory handshake for fetch/load/store, and reports halt/illegal status.
// Optional bus watchdog: define KTC32_BUSWDT_EN to enable it.
module ktc32_ctrl #(
    parameter int unsigned WDT_CYCLES = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [31:0]         instr,
    input  logic                zero,
    ktc32_ctrl_if.master        bus,
    output logic                pcen,
    output logic                iord,
    output logic                irwrite,
    output logic                memtoreg,
    output logic                regwrite,
    output logic                alusrca,
    output logic                pcsrc,
    output logic [1:0]          alusrcb,
    output logic [2:0]          alucontrol,
    output logic                halted,
    output logic                illegal,
    output logic                buserr
);

    localparam logic [2:0] AluAnd = 3'b000;
    localparam logic [2:0] AluOr  = 3'b001;
    localparam logic [2:0] AluAdd = 3'b010;
    localparam logic [2:0] AluSub = 3'b110;
    localparam logic [2:0] AluSlt = 3'b111;

    typedef enum logic [3:0] {
        StRst, StFetch, StDecode, StExec, StExeci, StAluwb, StMemadr,
        StMemrd, StMemwr, StMemwb, StBranch, StJump, StHalt, StIllegal
    } state_e;

    // Registered control word; fetch/branch/jump are the pcen/irwrite qualifiers.
    typedef struct packed {
        logic       fetch;
        logic       branch;
        logic       jump;
        logic       iord;
        logic       memtoreg;
        logic       regwrite;
        logic       alusrca;
        logic       pcsrc;
        logic [1:0] alusrcb;
        logic [2:0] alucontrol;
        logic       mem_req;
        logic       mem_we;
        logic       halted;
        logic       illegal;
    } ctrl_t;

    state_e      state_q, state_d;
    ctrl_t       ctrl_q;
    logic [5:0]  op;
    logic        unused_instr;

    assign op           = instr[5:0];
    assign unused_instr = ^instr[31:6];  // imm/target are consumed by the datapath

    if (WDT_CYCLES == 0) begin : g_wdt_cfg_check
        $error("ktc32_ctrl: WDT_CYCLES must be at least 1");
    end

    function automatic logic [2:0] alu_op(input logic [5:0] opc);
        logic [2:0] f;
        case (opc)
            6'b000010:           f = AluSub;
            6'b000100, 6'b000101: f = AluAnd;
            6'b000110, 6'b000111: f = AluOr;
            6'b001000:           f = AluSlt;
            default:             f = AluAdd;
        endcase
        return f;
    endfunction

    // Moore decode of a state into its control word.
    function automatic ctrl_t decode(input state_e st, input logic [5:0] opc);
        ctrl_t c;
        c = '0;
        case (st)
            StFetch: begin
                c.fetch      = 1'b1;
                c.mem_req    = 1'b1;
                c.alusrcb    = 2'b01;
                c.alucontrol = AluAdd;
            end
            StExec, StExeci: begin
                c.alusrca    = 1'b1;
                c.alusrcb    = (st == StExeci) ? 2'b11 : 2'b00;
                c.alucontrol = alu_op(opc);
            end
            StAluwb: c.regwrite = 1'b1;
            // Memory states keep the address selects so aluout stays stable.
            StMemadr, StMemrd, StMemwr: begin
                c.alusrca    = 1'b1;
                c.alusrcb    = opc[0] ? 2'b11 : 2'b10;
                c.alucontrol = AluAdd;
                c.iord       = (st != StMemadr);
                c.mem_req    = (st != StMemadr);
                c.mem_we     = (st == StMemwr);
            end
            StMemwb: begin
                c.memtoreg = 1'b1;
                c.regwrite = 1'b1;
            end
            StBranch: begin
                c.branch     = 1'b1;
                c.alusrca    = 1'b1;
                c.alusrcb    = 2'b00;
                c.alucontrol = AluSub;
                c.pcsrc      = 1'b1;
            end
            StJump: begin
                c.jump  = 1'b1;
                c.pcsrc = 1'b1;
            end
            StHalt:    c.halted  = 1'b1;
            StIllegal: c.illegal = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

`ifdef KTC32_BUSWDT_EN
    localparam int unsigned WdtW =
        ($clog2(WDT_CYCLES + 1) > 8) ? $clog2(WDT_CYCLES + 1) : 8;

    logic [WdtW-1:0] wdt_q;
    logic            buserr_q;
    logic            wdt_trip;

    // Trips on the stalled cycle that brings the count up to WDT_CYCLES.
    assign wdt_trip = ctrl_q.mem_req && !bus.mem_ack && (wdt_q == WdtW'(WDT_CYCLES - 1));

    // Count consecutive stalled request cycles; latch the sticky bus error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wdt_q    <= '0;
            buserr_q <= 1'b0;
        end else begin
            if (ctrl_q.mem_req && !bus.mem_ack) wdt_q <= wdt_q + WdtW'(1);
            else                                wdt_q <= '0;
            if (wdt_trip) buserr_q <= 1'b1;
        end
    end

    assign buserr = buserr_q;
`else
    assign buserr = 1'b0;
`endif

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StRst:   state_d = StFetch;
            StFetch: if (bus.mem_ack) state_d = StDecode;
            StDecode: begin
                case (op)
                    6'b000000, 6'b000010, 6'b000100,
                    6'b000110, 6'b001000:            state_d = StExec;
                    6'b000001, 6'b000101, 6'b000111: state_d = StExeci;
                    6'b001010, 6'b001100,
                    6'b001011, 6'b001101:            state_d = StMemadr;
                    6'b010001:                       state_d = StBranch;
                    6'b010011:                       state_d = StJump;
                    6'b111110:                       state_d = StHalt;
                    default:                         state_d = StIllegal;
                endcase
            end
            StExec, StExeci:                      state_d = StAluwb;
            StAluwb, StMemwb, StBranch, StJump:   state_d = StFetch;
            StMemadr: state_d = (op[5:1] == 5'b00101) ? StMemrd : StMemwr;
            StMemrd:  if (bus.mem_ack) state_d = StMemwb;
            StMemwr:  if (bus.mem_ack) state_d = StFetch;
            StHalt, StIllegal:                    state_d = state_q;
            default:                              state_d = StIllegal;
        endcase
`ifdef KTC32_BUSWDT_EN
        if (wdt_trip) state_d = StIllegal;
`endif
    end

    // State register with outputs registered from the next state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StRst;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= decode(state_d, op);
        end
    end

    assign irwrite     = ctrl_q.fetch & bus.mem_ack;
    assign pcen        = (ctrl_q.fetch & bus.mem_ack) | (ctrl_q.branch & zero) | ctrl_q.jump;
    assign iord        = ctrl_q.iord;
    assign memtoreg    = ctrl_q.memtoreg;
    assign regwrite    = ctrl_q.regwrite;
    assign alusrca     = ctrl_q.alusrca;
    assign pcsrc       = ctrl_q.pcsrc;
    assign alusrcb     = ctrl_q.alusrcb;
    assign alucontrol  = ctrl_q.alucontrol;
    assign halted      = ctrl_q.halted;
    assign illegal     = ctrl_q.illegal;
    assign bus.mem_req = ctrl_q.mem_req;
    assign bus.mem_we  = ctrl_q.mem_we;

endmodule

// File: tb/tb_ktc32_ctrl.sv
// tb_ktc32_ctrl: randomized self-checking bench for ktc32_ctrl. Each instruction
// is expanded into an expected per-cycle trace of control outputs from its class
// and the chosen memory wait counts, then played against the DUT.
module tb_ktc32_ctrl;

    typedef struct packed {
        logic       pcen, iord, irwrite, memtoreg, regwrite, alusrca, pcsrc;
        logic [1:0] alusrcb;
        logic [2:0] alucontrol;
        logic       mem_req, mem_we, halted, illegal, buserr;
    } out_t;

    typedef struct packed {
        logic [31:0] iw;
        logic        ack;
        logic        z;
        out_t        exp;
    } cyc_t;

    typedef enum int {CR, CI, CLD, CST, CBR, CJ, CH, CX} cls_e;

    logic        clk, reset, zero, mem_ack;
    logic [31:0] instr;
    logic        pcen, iord, irwrite, memtoreg, regwrite, alusrca, pcsrc;
    logic [1:0]  alusrcb;
    logic [2:0]  alucontrol;
    logic        halted, illegal, buserr;
    out_t        obs_now;
    cyc_t        q[$];
    int          n_checks, n_fail;

    ktc32_ctrl_if bus ();
    assign bus.mem_ack = mem_ack;

    ktc32_ctrl #(.WDT_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .instr(instr), .zero(zero), .bus(bus.master),
        .pcen(pcen), .iord(iord), .irwrite(irwrite), .memtoreg(memtoreg),
        .regwrite(regwrite), .alusrca(alusrca), .pcsrc(pcsrc), .alusrcb(alusrcb),
        .alucontrol(alucontrol), .halted(halted), .illegal(illegal), .buserr(buserr)
    );

    assign obs_now = {pcen, iord, irwrite, memtoreg, regwrite, alusrca, pcsrc, alusrcb,
                      alucontrol, bus.mem_req, bus.mem_we, halted, illegal, buserr};

    always #5 clk = ~clk;

    function automatic cls_e cls_of(input logic [5:0] op);
        case (op)
            6'b000000, 6'b000010, 6'b000100, 6'b000110, 6'b001000: return CR;
            6'b000001, 6'b000101, 6'b000111:                       return CI;
            6'b001010, 6'b001011:                                  return CLD;
            6'b001100, 6'b001101:                                  return CST;
            6'b010001:                                             return CBR;
            6'b010011:                                             return CJ;
            6'b111110:                                             return CH;
            default:                                               return CX;
        endcase
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] op);
        case (op)
            6'b000010:            return 3'b110;
            6'b000100, 6'b000101: return 3'b000;
            6'b000110, 6'b000111: return 3'b001;
            6'b001000:            return 3'b111;
            default:              return 3'b010;
        endcase
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic push(input logic [31:0] iw, input logic a, input logic z, input out_t o);
        cyc_t c;
        c.iw = iw; c.ack = a; c.z = z; c.exp = o;
        q.push_back(c);
    endtask

    // Expected trace of one instruction: fw fetch stalls, mw memory stalls.
    task automatic push_instr(input logic [5:0] op, input logic [15:0] imm,
                              input int fw, input int mw, input logic z);
        logic [31:0] iw;
        out_t        o;
        cls_e        c;
        iw = {imm, 10'h000, op};
        c  = cls_of(op);
        for (int i = 0; i <= fw; i++) begin
            o = '0; o.mem_req = 1; o.alusrcb = 2'b01; o.alucontrol = 3'b010;
            if (i == fw) begin o.irwrite = 1; o.pcen = 1; end
            push(iw, i == fw, rb(), o);
        end
        o = '0;
        push(iw, rb(), rb(), o);
        case (c)
            CR, CI: begin
                o.alusrca = 1; o.alusrcb = (c == CI) ? 2'b11 : 2'b00; o.alucontrol = alu_of(op);
                push(iw, rb(), rb(), o);
                o = '0; o.regwrite = 1;
                push(iw, rb(), rb(), o);
            end
            CLD, CST: begin
                o.alusrca = 1; o.alusrcb = op[0] ? 2'b11 : 2'b10; o.alucontrol = 3'b010;
                push(iw, rb(), rb(), o);
                o.iord = 1; o.mem_req = 1; o.mem_we = (c == CST);
                for (int i = 0; i <= mw; i++) push(iw, i == mw, rb(), o);
                if (c == CLD) begin
                    o = '0; o.memtoreg = 1; o.regwrite = 1;
                    push(iw, rb(), rb(), o);
                end
            end
            CBR: begin
                o.alusrca = 1; o.alucontrol = 3'b110; o.pcsrc = 1; o.pcen = z;
                push(iw, rb(), z, o);
            end
            CJ: begin
                o.pcsrc = 1; o.pcen = 1;
                push(iw, rb(), rb(), o);
            end
            CH: begin
                o.halted = 1;
                for (int i = 0; i < 6; i++) push(iw, rb(), rb(), o);
            end
            default: begin
                o.illegal = 1;
                for (int i = 0; i < 6; i++) push(iw, rb(), rb(), o);
            end
        endcase
    endtask

    task automatic push_rst_cycle();
        out_t o;
        o = '0;
        push(32'h0, rb(), rb(), o);
    endtask

    // Drive one cycle, sample at the falling edge, return at posedge+1.
    task automatic step(input logic a, input logic z, output out_t o);
        mem_ack = a; zero = z;
        @(negedge clk);
        o = obs_now;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        out_t o;
        reset = 0; instr = 32'h0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, rb(), o);
            n_checks++;
            if (o !== out_t'(0)) begin
                n_fail++;
                $display("FAIL reset_hold cyc%0d: got %h expected %h", i, o, out_t'(0));
            end
        end
        reset = 1;
        push_rst_cycle();
        push_instr(6'b000000, 16'h0, 0, 0, 1'b0);
        for (int k = 0; q.size() > 0; k++) begin
            cyc_t c = q.pop_front();
            instr = c.iw; step(c.ack, c.z, o);
            n_checks++;
            if (o !== c.exp) begin
                n_fail++;
                $display("FAIL reset_release cyc%0d: got %h expected %h", k, o, c.exp);
            end
        end
    endtask

    task automatic test_add_wait();
        out_t o;
        push_instr(6'b000000, 16'h0, 2, 0, 1'b0);
        for (int k = 0; q.size() > 0; k++) begin
            cyc_t c = q.pop_front();
            instr = c.iw; step(c.ack, c.z, o);
            n_checks++;
            if (o !== c.exp) begin
                n_fail++;
                $display("FAIL add_wait cyc%0d: got %h expected %h", k, o, c.exp);
            end
        end
    endtask

    task automatic test_load_store();
        out_t o;
        push_instr(6'b001011, 16'h0040, 0, 1, 1'b0);
        push_instr(6'b001100, 16'h0000, 0, int'($urandom_range(0, 2)), 1'b0);
        for (int k = 0; q.size() > 0; k++) begin
            cyc_t c = q.pop_front();
            instr = c.iw; step(c.ack, c.z, o);
            n_checks++;
            if (o !== c.exp) begin
                n_fail++;
                $display("FAIL load_store cyc%0d: got %h expected %h", k, o, c.exp);
            end
        end
    endtask

    task automatic test_branch();
        out_t o;
        push_instr(6'b010001, 16'h0010, 0, 0, 1'b1);
        push_instr(6'b010001, 16'h0020, 1, 0, 1'b0);
        push_instr(6'b010011, 16'h0100, 0, 0, 1'b0);
        for (int k = 0; q.size() > 0; k++) begin
            cyc_t c = q.pop_front();
            instr = c.iw; step(c.ack, c.z, o);
            n_checks++;
            if (o !== c.exp) begin
                n_fail++;
                $display("FAIL branch cyc%0d: got %h expected %h", k, o, c.exp);
            end
        end
    endtask

    task automatic test_random();
        logic [5:0] ops [14];
        out_t o;
        ops = '{6'b000000, 6'b000010, 6'b000100, 6'b000110, 6'b001000, 6'b001010, 6'b001100,
                6'b000001, 6'b000101, 6'b000111, 6'b001011, 6'b001101, 6'b010001, 6'b010011};
        for (int n = 0; n < 40; n++)
            push_instr(ops[$urandom_range(0, 13)], 16'($urandom), int'($urandom_range(0, 3)),
                       int'($urandom_range(0, 3)), rb());
        for (int k = 0; q.size() > 0; k++) begin
            cyc_t c = q.pop_front();
            instr = c.iw; step(c.ack, c.z, o);
            n_checks++;
            if (o !== c.exp) begin
                n_fail++;
                $display("FAIL random cyc%0d instr %h: got %h expected %h", k, c.iw, o, c.exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        out_t o;
        // Stop inside the load's memory wait with mem_req pending.
        push_instr(6'b001010, 16'h0, 0, 5, 1'b0);
        for (int k = 0; k < 4; k++) begin
            cyc_t c = q.pop_front();
            instr = c.iw; step(c.ack, c.z, o);
            n_checks++;
            if (o !== c.exp) begin
                n_fail++;
                $display("FAIL reset_mid_pre cyc%0d: got %h expected %h", k, o, c.exp);
            end
        end
        q.delete();
        mem_ack = 0;
        reset = 0;
        #1;
        n_checks++;
        if (obs_now !== out_t'(0)) begin
            n_fail++;
            $display("FAIL reset_mid_abort: got %h expected %h", obs_now, out_t'(0));
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
        push_rst_cycle();
        push_instr(6'b010011, 16'h0, 0, 0, 1'b0);
        for (int k = 0; q.size() > 0; k++) begin
            cyc_t c = q.pop_front();
            instr = c.iw; step(c.ack, c.z, o);
            n_checks++;
            if (o !== c.exp) begin
                n_fail++;
                $display("FAIL reset_mid_restart cyc%0d: got %h expected %h", k, o, c.exp);
            end
        end
    endtask

    task automatic test_terminal();
        out_t o;
        for (int t = 0; t < 2; t++) begin
            push_instr((t == 0) ? 6'b011110 : 6'b111110, 16'h0, int'($urandom_range(0, 2)),
                       0, 1'b0);
            for (int k = 0; q.size() > 0; k++) begin
                cyc_t c = q.pop_front();
                instr = c.iw; step(c.ack, c.z, o);
                n_checks++;
                if (o !== c.exp) begin
                    n_fail++;
                    $display("FAIL terminal%0d cyc%0d: got %h expected %h", t, k, o, c.exp);
                end
            end
            reset = 0;
            #1;
            n_checks++;
            if (obs_now !== out_t'(0)) begin
                n_fail++;
                $display("FAIL terminal%0d_clear: got %h expected %h", t, obs_now, out_t'(0));
            end
            repeat (2) @(posedge clk);
            #1;
            reset = 1;
            push_rst_cycle();
        end
        push_instr(6'b010011, 16'h0, 0, 0, 1'b0);
        for (int k = 0; q.size() > 0; k++) begin
            cyc_t c = q.pop_front();
            instr = c.iw; step(c.ack, c.z, o);
            n_checks++;
            if (o !== c.exp) begin
                n_fail++;
                $display("FAIL terminal_restart cyc%0d: got %h expected %h", k, o, c.exp);
            end
        end
    endtask

    task automatic test_watchdog();
        out_t o, f;
        f = '0; f.mem_req = 1; f.alusrcb = 2'b01; f.alucontrol = 3'b010;
`ifdef KTC32_BUSWDT_EN
        for (int i = 0; i < 4; i++) push(32'h0, 1'b0, rb(), f);
        f = '0; f.illegal = 1; f.buserr = 1;
        for (int i = 0; i < 5; i++) push(32'h0, rb(), rb(), f);
`else
        for (int i = 0; i < 20; i++) push(32'h0, 1'b0, rb(), f);
`endif
        for (int k = 0; q.size() > 0; k++) begin
            cyc_t c = q.pop_front();
            instr = c.iw; step(c.ack, c.z, o);
            n_checks++;
            if (o !== c.exp) begin
                n_fail++;
                $display("FAIL watchdog cyc%0d: got %h expected %h", k, o, c.exp);
            end
        end
        reset = 0;
        #1;
        n_checks++;
        if (obs_now !== out_t'(0)) begin
            n_fail++;
            $display("FAIL watchdog_clear: got %h expected %h", obs_now, out_t'(0));
        end
        repeat (2) @(posedge clk);
        #1;
        reset = 1;
    endtask

    initial begin
        clk = 0; reset = 0; zero = 0; mem_ack = 1; instr = 32'h0;
        n_checks = 0; n_fail = 0;
        test_reset();
        test_add_wait();
        test_load_store();
        test_branch();
        test_random();
        test_reset_mid();
        test_terminal();
        test_watchdog();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ktc32_ctrl.md
Name: ktc32_ctrl

Overview:
Multicycle main control FSM for the ktc32 core. Sits directly upstream of the datapath and drives every datapath select and enable from the registered instruction and the ALU zero flag. Also owns the memory request/acknowledge handshake for fetch, load and store. Reports halt and illegal-opcode status.

Parameters:
WDT_CYCLES, 255, bus-watchdog limit in cycles of mem_req high without mem_ack (used only with KTC32_BUSWDT_EN)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous reset, active-low (0 = reset)
instr  in  32  registered instruction from datapath; [5:0] opcode (bit0=1 means 32-bit form), [31:16] imm/target
zero  in  1  ALU zero flag
mem_ack  in  1  memory completes current access this cycle
pcen, iord, irwrite, memtoreg, regwrite, alusrca, pcsrc  out  1 each  datapath controls
alusrcb  out  2  00 b, 01 pc increment, 10 zero, 11 imm
alucontrol  out  3  000 AND, 001 OR, 010 ADD, 110 SUB, 111 SLT
mem_req  out  1  memory access request
mem_we  out  1  store qualifier, valid only with mem_req
halted  out  1  sticky, HALT executed
illegal  out  1  sticky, undefined opcode decoded
buserr  out  1  sticky watchdog error (tied 0 without macro)

Behaviour:
- Moore FSM. All outputs are decoded from the state register only, except pcen and irwrite, which are also gated by mem_ack or zero.
- Reset asserted: state = RST and all outputs 0. RST -> FETCH on the first clock after release.
- Outputs not listed for a state are 0.
- FETCH: mem_req=1, iord=0, alusrca=0, alusrcb=01, alucontrol=ADD, pcsrc=0.
  - irwrite=pcen=mem_ack. Stay in FETCH until mem_ack=1, then go to DECODE.
- DECODE: 1 cycle; a/b registers load. Next state by opcode:
  - short forms: 000000 ADD, 000010 SUB, 000100 AND, 000110 OR, 001000 SLT -> EXEC.
  - 001010 LW, 001100 SW -> MEMADR (address = rs + 0).
  - 111110 HALT -> HALT.
  - long forms: 000001 ADDI, 000101 ANDI, 000111 ORI -> EXECI.
  - 001011 LWI, 001101 SWI -> MEMADR (address = rs + imm).
  - 010001 BEQ -> BRANCH; 010011 JMP -> JUMP.
  - any other opcode -> ILLEGAL.
- EXEC: alusrca=1, alusrcb=00, alucontrol per opcode. Next state ALUWB.
- EXECI: alusrca=1, alusrcb=11, alucontrol per opcode. Next state ALUWB.
- ALUWB: regwrite=1, memtoreg=0. Next state FETCH.
- MEMADR: alusrca=1, alusrcb=10 (short) or 11 (long), ADD. Next state MEMRD for loads, MEMWR for stores.
- MEMRD / MEMWR: keep the MEMADR ALU selects so aluout stays stable; iord=1, mem_req=1, mem_we=1 in MEMWR only.
  - Stay in the state until mem_ack. MEMRD -> MEMWB; MEMWR -> FETCH.
- MEMWB: memtoreg=1, regwrite=1 (datareg holds the load data captured at the ack edge). Next state FETCH.
- BRANCH: alusrca=1, alusrcb=00, SUB, pcsrc=1, pcen=zero. Next state FETCH.
- JUMP: pcsrc=1, pcen=1. Next state FETCH.
- HALT and ILLEGAL: terminal until reset. halted=1 or illegal=1 respectively; no mem_req, no writes.
- Handshake:
  - mem_req stays high and iord/mem_we stay constant until mem_ack is sampled 1.
  - Same-cycle ack (zero wait) is legal.
  - mem_ack while mem_req=0 is ignored.
  - mem_req drops in the cycle after the ack edge.
- Minimum latency with zero-wait memory: R/I-type 4 cycles, LW 5, SW 4, BEQ 3, JMP 3.
- Reset mid-operation (including a pending mem_req) aborts immediately: mem_req=0 asynchronously, state=RST.

Optional Feature:
KTC32_BUSWDT_EN
- Defined:
  - 8-bit-minimum counter increments each cycle that mem_req=1 and mem_ack=0; it clears on ack or when mem_req=0.
  - When the count reaches WDT_CYCLES, the FSM goes to ILLEGAL and sets buserr=1 (sticky until reset).
- Not defined: no counter; buserr tied 0; a memory wait may be unbounded.

Test Plan:
- Reset low for 3 cycles, release, mem_ack always 1 -> all outputs 0 during reset; FETCH with mem_req=1, irwrite=1, pcen=1 on the 2nd cycle after release.
- ADD (instr=32'h0000_0000), mem_ack held 0 for 2 cycles in FETCH -> mem_req stays 1 for 3 cycles; irwrite/pcen pulse once; regwrite=1 exactly in the 6th state cycle (ALUWB).
- LWI imm=16'h0040 then SW, ack delayed 1 cycle in MEMRD -> iord=1, alusrcb=11 stable through MEMRD; MEMWB memtoreg=1, regwrite=1; SW shows mem_we=1, alusrcb=10.
- BEQ (opcode 010001), zero=1 then zero=0 -> pcen=1, pcsrc=1 in BRANCH for the first; pcen=0 for the second; FETCH follows in both cases.
- Opcode 6'b011110 -> illegal=1 permanently, mem_req=0; HALT opcode -> halted=1; both clear only on reset.
- With KTC32_BUSWDT_EN and WDT_CYCLES=4, mem_ack stuck 0 in FETCH -> buserr=1 and illegal=1 after 4 cycles; without the macro, mem_req stays 1 indefinitely and buserr=0.
